// File: rtl/int2float_pkg.sv
// int2float_pkg: shared widths, result struct and result-register state encoding.
package int2float_pkg;
   localparam int INT_W = 11;
   localparam int MAN_W = 4;
   localparam int EXP_W = 3;
   typedef struct packed {
      logic [MAN_W-1:0] man;
      logic [EXP_W-1:0] exp;
   } int2float_res_t;
   typedef enum logic {RES_EMPTY, RES_FULL} res_state_e;
endpackage

// File: rtl/int2float_core.sv
// int2float_core: combinational 11-bit unsigned integer to 4-bit mantissa / 3-bit exponent.
module int2float_core
   import int2float_pkg::*;
(
   input  logic [INT_W-1:0] value,
   output int2float_res_t   res
);
   // The highest set bit at or above bit 4 wins; lower bits are truncated.
   always_comb begin
      res.man = value[MAN_W-1:0];
      res.exp = '0;
      for (int p = MAN_W; p < INT_W; p++) begin
         if (value[p]) begin
            res.man = value[p -: MAN_W];
            res.exp = EXP_W'(p - (MAN_W - 1));
         end
      end
   end
endmodule

// File: rtl/int2float_arbiter.sv
// int2float_arbiter: round-robin sharing of one int2float_core with a registered result channel.
// Define INT2FLOAT_ARB_STATS_EN to add per-requester saturating grant counters.
module int2float_arbiter
   import int2float_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_en,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*INT_W-1:0] req_data,
`ifdef INT2FLOAT_ARB_STATS_EN
   input  logic [ID_W-1:0]          stat_sel,
   input  logic                     stat_clr,
   output logic [15:0]              stat_cnt,
`endif
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [MAN_W-1:0]         res_m,
   output logic [EXP_W-1:0]         res_e,
   output logic [ID_W-1:0]          res_id
);
   res_state_e       state, state_nxt;
   logic [ID_W-1:0]  rr_ptr, gnt_id;
   logic [NUM_REQ-1:0] grant;
   logic             found, slot_free, xfer;
   logic [INT_W-1:0] sel_data;
   int2float_res_t   conv;

   always_comb begin
      grant  = '0;
      gnt_id = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            found  = 1'b1;
            gnt_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
         end
      end
   end

   assign res_valid = (state == RES_FULL);
   assign slot_free = ~res_valid | res_ready;
   assign req_ready = {NUM_REQ{rst_n & cfg_en & slot_free}} & grant;
   assign xfer      = rst_n & cfg_en & slot_free & found;
   assign sel_data  = req_data[int'(gnt_id)*INT_W +: INT_W];

   int2float_core u_core (.value(sel_data), .res(conv));

   always_comb begin
      state_nxt = xfer ? RES_FULL : (res_ready ? RES_EMPTY : state);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RES_EMPTY;
         rr_ptr <= '0;
         res_m  <= '0;
         res_e  <= '0;
         res_id <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            res_m  <= conv.man;
            res_e  <= conv.exp;
            res_id <= gnt_id;
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
         end
      end
   end

`ifdef INT2FLOAT_ARB_STATS_EN
   logic [15:0] cnt [NUM_REQ];

   assign stat_cnt = cnt[stat_sel];

   // Clear takes priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else if (xfer && cnt[gnt_id] != 16'hFFFF) begin
         cnt[gnt_id] <= cnt[gnt_id] + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_int2float_arbiter.sv
// tb_int2float_arbiter: directed self-checking bench for int2float_arbiter.
module tb_int2float_arbiter;
   localparam int N = 4;
   logic          clk = 0;
   logic          rst_n = 0;
   logic          cfg_en = 1;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [N*11-1:0] req_data = '0;
   logic          res_valid, res_ready = 1;
   logic [3:0]    res_m;
   logic [2:0]    res_e;
   logic [1:0]    res_id;
`ifdef INT2FLOAT_ARB_STATS_EN
   logic [1:0]    stat_sel = '0;
   logic          stat_clr = 0;
   logic [15:0]   stat_cnt;
`endif
   int tests = 0;
   int fails = 0;

   int2float_arbiter #(.NUM_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
`ifdef INT2FLOAT_ARB_STATS_EN
      .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt),
`endif
      .res_valid(res_valid), .res_ready(res_ready),
      .res_m(res_m), .res_e(res_e), .res_id(res_id)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [10:0] v);
      req_data[i*11 +: 11] = v;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", res_valid); end
      tests++; if ({res_m, res_e, res_id} !== 9'd0) begin fails++; $display("FAIL reset_regs got m=%0d e=%0d id=%0d want 0", res_m, res_e, res_id); end
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
      req_valid = '0;
      step();
      rst_n = 1;
      step();
   endtask

   task automatic test_single();
      set_data(0, 11'd100);
      req_valid = 4'b0001;
      res_ready = 1;
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b want 0001", req_ready); end
      step();
      req_valid = '0;
      tests++; if (res_valid !== 1'b1 || res_m !== 4'd12 || res_e !== 3'd3 || res_id !== 2'd0)
         begin fails++; $display("FAIL single_result got v=%0b m=%0d e=%0d id=%0d want v=1 m=12 e=3 id=0", res_valid, res_m, res_e, res_id); end
   endtask

   task automatic test_values();
      logic [10:0] vals [4] = '{11'd0, 11'd13, 11'd16, 11'd2047};
      logic [3:0]  em   [4] = '{4'd0, 4'd13, 4'd8, 4'd15};
      logic [2:0]  ee   [4] = '{3'd0, 3'd0, 3'd1, 3'd7};
      req_valid = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         set_data(2, vals[k]);
         step();
         tests++; if (res_valid !== 1'b1 || res_m !== em[k] || res_e !== ee[k] || res_id !== 2'd2)
            begin fails++; $display("FAIL values_%0d got v=%0b m=%0d e=%0d id=%0d want v=1 m=%0d e=%0d id=2", vals[k], res_valid, res_m, res_e, res_id, em[k], ee[k]); end
      end
      req_valid = '0;
      step();
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL values_drain got %0b want 0", res_valid); end
   endtask

   task automatic test_round_robin();
      int e = 3;
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         tests++; if (req_ready !== 4'(1 << e)) begin fails++; $display("FAIL rr_ready_%0d got %b want %b", k, req_ready, 4'(1 << e)); end
         step();
         tests++; if (res_valid !== 1'b1 || res_id !== 2'(e)) begin fails++; $display("FAIL rr_id_%0d got v=%0b id=%0d want v=1 id=%0d", k, res_valid, res_id, e); end
         e = (e + 1) % 4;
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_back_pressure();
      res_ready = 0;
      set_data(0, 11'd2047);
      req_valid = 4'b0001;
      step();
      set_data(1, 11'd16);
      req_valid = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         #1;
         tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready_%0d got %b want 0000", k, req_ready); end
         tests++; if (res_valid !== 1'b1 || res_m !== 4'd15 || res_e !== 3'd7 || res_id !== 2'd0)
            begin fails++; $display("FAIL bp_hold_%0d got v=%0b m=%0d e=%0d id=%0d want v=1 m=15 e=7 id=0", k, res_valid, res_m, res_e, res_id); end
         step();
      end
      res_ready = 1;
      #1;
      tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_release_ready got %b want 0010", req_ready); end
      step();
      req_valid = '0;
      tests++; if (res_valid !== 1'b1 || res_m !== 4'd8 || res_e !== 3'd1 || res_id !== 2'd1)
         begin fails++; $display("FAIL bp_new got v=%0b m=%0d e=%0d id=%0d want v=1 m=8 e=1 id=1", res_valid, res_m, res_e, res_id); end
      step();
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %0b want 0", res_valid); end
   endtask

   task automatic test_cfg_en();
      res_ready = 0;
      set_data(3, 11'd5);
      req_valid = 4'b1000;
      step();
      tests++; if (res_valid !== 1'b1 || res_m !== 4'd5 || res_e !== 3'd0 || res_id !== 2'd3)
         begin fails++; $display("FAIL cfg_load got v=%0b m=%0d e=%0d id=%0d want v=1 m=5 e=0 id=3", res_valid, res_m, res_e, res_id); end
      cfg_en = 0;
      req_valid = 4'b1111;
      res_ready = 1;
      #1;
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL cfg_block got %b want 0000", req_ready); end
      step();
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL cfg_drain got %0b want 0", res_valid); end
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL cfg_block2 got %b want 0000", req_ready); end
      cfg_en = 1;
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL cfg_ptr_held got %b want 0001", req_ready); end
      req_valid = '0;
      step();
   endtask

   task automatic test_async_reset();
      res_ready = 0;
      set_data(2, 11'd1000);
      req_valid = 4'b0100;
      step();
      tests++; if (res_valid !== 1'b1 || res_m !== 4'd15 || res_e !== 3'd6 || res_id !== 2'd2)
         begin fails++; $display("FAIL ar_load got v=%0b m=%0d e=%0d id=%0d want v=1 m=15 e=6 id=2", res_valid, res_m, res_e, res_id); end
      req_valid = 4'b1111;
      #2 rst_n = 0;
      #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL ar_clear got %0b want 0", res_valid); end
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL ar_ready got %b want 0000", req_ready); end
      #1 rst_n = 1;
      res_ready = 1;
      set_data(0, 11'd3);
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL ar_first_grant got %b want 0001", req_ready); end
      step();
      req_valid = '0;
      tests++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_m !== 4'd3 || res_e !== 3'd0)
         begin fails++; $display("FAIL ar_result got v=%0b m=%0d e=%0d id=%0d want v=1 m=3 e=0 id=0", res_valid, res_m, res_e, res_id); end
      step();
   endtask

`ifdef INT2FLOAT_ARB_STATS_EN
   task automatic test_stats();
      stat_sel = 2'd3;
      set_data(3, 11'd1);
      req_valid = 4'b1000;
      res_ready = 1;
      for (int k = 0; k < 10; k++) step();
      req_valid = '0;
      #1;
      tests++; if (stat_cnt !== 16'd10) begin fails++; $display("FAIL stats_count got %0d want 10", stat_cnt); end
      req_valid = 4'b1000;
      stat_clr = 1;
      step();
      stat_clr = 0;
      req_valid = '0;
      tests++; if (res_valid !== 1'b1 || stat_cnt !== 16'd0) begin fails++; $display("FAIL stats_clear got v=%0b cnt=%0d want v=1 cnt=0", res_valid, stat_cnt); end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_values();
      test_round_robin();
      test_back_pressure();
      test_cfg_en();
      test_async_reset();
`ifdef INT2FLOAT_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
